// File: rtl/mips_encoder_pkg.sv
// Shared MIPS32 encoding constants, request type codes and the packed
// field bundle used between the encoder stages.
package mips_encoder_pkg;

    typedef enum logic [1:0] {
        TYPE_R   = 2'b00,
        TYPE_I   = 2'b01,
        TYPE_J   = 2'b10,
        TYPE_ILL = 2'b11
    } instr_type_e;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;

    // One captured request, exactly as presented on the input bus.
    typedef struct packed {
        instr_type_e itype;
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
    } req_fields_t;

    // One-hot instruction class of an encoded word.
    typedef struct packed {
        logic r;
        logic i;
        logic j;
    } instr_cls_t;

    function automatic logic is_jump_op(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/mips_encoder_if.sv
// Request/response bus of the MIPS encoder. The slave modport is the
// encoder's view; the master modport is the producer/consumer side.
interface mips_encoder_if #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned ERR_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_type;
    logic [5:0]           opcode;
    logic [4:0]           rs;
    logic [4:0]           rt;
    logic [4:0]           rd;
    logic [4:0]           shamt;
    logic [5:0]           funct;
    logic [15:0]          imm;
    logic [25:0]          target;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_instr;
    logic [ADDR_W-1:0]    out_addr;
    logic                 out_r;
    logic                 out_i;
    logic                 out_j;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output in_valid, in_type, opcode, rs, rt, rd, shamt, funct, imm, target,
        output out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_r, out_i, out_j,
        input  err, err_count
    );

    modport slave (
        input  in_valid, in_type, opcode, rs, rt, rd, shamt, funct, imm, target,
        input  out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_r, out_i, out_j,
        output err, err_count
    );
endinterface

// File: rtl/mips_field_pack.sv
// Combinational packer: turns one captured field bundle into a MIPS32
// word, its one-hot class and a legality flag.
module mips_field_pack
    import mips_encoder_pkg::*;
(
    input  req_fields_t i_req,
    output logic [31:0] o_word,
    output logic        o_legal,
    output instr_cls_t  o_cls
);

    // Select encoding by request type; illegal requests yield no class.
    always_comb begin
        o_word  = '0;
        o_legal = 1'b0;
        o_cls   = '0;
        case (i_req.itype)
            TYPE_R: begin
                o_word  = {OP_RTYPE, i_req.rs, i_req.rt, i_req.rd, i_req.shamt, i_req.funct};
                o_legal = 1'b1;
                o_cls.r = 1'b1;
            end
            TYPE_I: begin
                o_word  = {i_req.opcode, i_req.rs, i_req.rt, i_req.imm};
                o_legal = !((i_req.opcode == OP_RTYPE) || is_jump_op(i_req.opcode));
                o_cls.i = o_legal;
            end
            TYPE_J: begin
                o_word  = {i_req.opcode, i_req.target};
                o_legal = is_jump_op(i_req.opcode);
                o_cls.j = o_legal;
            end
            default: begin
                o_word  = '0;
                o_legal = 1'b0;
                o_cls   = '0;
            end
        endcase
    end

endmodule

// File: rtl/mips_encoder.sv
// MIPS32 instruction encoder: S1 captures request fields and checks
// legality, S2 holds the output word with its byte address.
module mips_encoder
    import mips_encoder_pkg::*;
#(
    parameter int unsigned             ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]       BASE_ADDR = '0,
    parameter int unsigned             ERR_CNT_W = 8
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    mips_encoder_if.slave bus
);

    logic                 r_s1_valid;
    req_fields_t          r_s1_req;
    logic                 r_out_valid;
    logic [31:0]          r_out_instr;
    instr_cls_t           r_out_cls;
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_err;
    logic [ERR_CNT_W-1:0] r_err_count;

    req_fields_t          w_in_req;
    logic [31:0]          w_word;
    logic                 w_legal;
    instr_cls_t           w_cls;
    logic                 w_s2_free;
    logic                 w_s2_load;
    logic                 w_s1_adv;
    logic                 w_s1_ill;
    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_out_hs;

    assign w_in_req = '{
        itype:  instr_type_e'(bus.in_type),
        opcode: bus.opcode,
        rs:     bus.rs,
        rt:     bus.rt,
        rd:     bus.rd,
        shamt:  bus.shamt,
        funct:  bus.funct,
        imm:    bus.imm,
        target: bus.target
    };

    mips_field_pack u_pack (
        .i_req   (r_s1_req),
        .o_word  (w_word),
        .o_legal (w_legal),
        .o_cls   (w_cls)
    );

    // Illegal S1 entries retire unconditionally; legal ones need room in S2.
    assign w_s2_free  = !r_out_valid || bus.out_ready;
    assign w_s2_load  = r_s1_valid && w_legal && w_s2_free;
    assign w_s1_adv   = r_s1_valid && (!w_legal || w_s2_free);
    assign w_s1_ill   = r_s1_valid && !w_legal;
    // rst_n gates ready so nothing is accepted while reset is held.
    assign w_in_ready = rst_n && !clr && (!r_s1_valid || w_s1_adv);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_out_hs   = r_out_valid && bus.out_ready;

    // S1: capture a request, release it when it advances or retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_req   <= '0;
        end else if (clr) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_req   <= w_in_req;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // S2: output word register and byte address advancing per handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_cls   <= '0;
            r_addr      <= BASE_ADDR;
        end else if (clr) begin
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_cls   <= '0;
            r_addr      <= BASE_ADDR;
        end else begin
            if (w_out_hs) begin
                r_addr <= r_addr + ADDR_W'(4);
            end
            if (w_s2_load) begin
                r_out_valid <= 1'b1;
                r_out_instr <= w_word;
                r_out_cls   <= w_cls;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Sticky error flag and saturating count of retired illegal requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else if (clr) begin
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else if (w_s1_ill) begin
            r_err <= 1'b1;
            if (r_err_count != '1) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_instr = r_out_instr;
    assign bus.out_addr  = r_addr;
    assign bus.out_r     = r_out_valid && r_out_cls.r;
    assign bus.out_i     = r_out_valid && r_out_cls.i;
    assign bus.out_j     = r_out_valid && r_out_cls.j;
    assign bus.err       = r_err;
    assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_mips_encoder.sv
// Directed bench for mips_encoder: a default-width instance plus a narrow
// instance (4-bit address, 2-bit error counter) fed the same stimulus.
module tb_mips_encoder;

    logic clk;
    logic rst_n;
    logic clr;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_acc    = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic [2:0]  cls;
    } word_t;
    word_t q[$];
    int unsigned qb;

    mips_encoder_if #(.ADDR_W(32), .ERR_CNT_W(8)) bm ();
    mips_encoder_if #(.ADDR_W(4),  .ERR_CNT_W(2)) bs ();

    mips_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0000_0000), .ERR_CNT_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bm.slave)
    );

    mips_encoder #(.ADDR_W(4), .BASE_ADDR(4'd12), .ERR_CNT_W(2)) u_small (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bs.slave)
    );

    assign bs.in_valid  = bm.in_valid;
    assign bs.in_type   = bm.in_type;
    assign bs.opcode    = bm.opcode;
    assign bs.rs        = bm.rs;
    assign bs.rt        = bm.rt;
    assign bs.rd        = bm.rd;
    assign bs.shamt     = bm.shamt;
    assign bs.funct     = bm.funct;
    assign bs.imm       = bm.imm;
    assign bs.target    = bm.target;
    assign bs.out_ready = bm.out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted requests and record every output handshake.
    always @(posedge clk) begin
        if (bm.in_valid && bm.in_ready) n_acc <= n_acc + 1;
        if (bm.out_valid && bm.out_ready)
            q.push_back('{bm.out_instr, bm.out_addr, {bm.out_r, bm.out_i, bm.out_j}});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] t, input logic [5:0] op,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh,
                         input logic [5:0] fn, input logic [15:0] im,
                         input logic [25:0] tg);
        int unsigned start;
        bit done;
        bm.in_type = t; bm.opcode = op; bm.rs = rs; bm.rt = rt; bm.rd = rd;
        bm.shamt = sh; bm.funct = fn; bm.imm = im; bm.target = tg;
        bm.in_valid = 1'b1;
        start = n_acc;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (n_acc != start) done = 1'b1;
        end
        bm.in_valid = 1'b0;
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [4:0] sh, input logic [5:0] fn);
        drive(2'b00, 6'd0, rs, rt, rd, sh, fn, 16'h0, 26'h0);
    endtask

    task automatic send_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [15:0] im);
        drive(2'b01, op, rs, rt, 5'd0, 5'd0, 6'd0, im, 26'h0);
    endtask

    task automatic send_j(input logic [5:0] op, input logic [25:0] tg);
        drive(2'b10, op, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, tg);
    endtask

    task automatic send_ill();
        drive(2'b11, 6'd8, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 16'h1234, 26'h0);
    endtask

    task automatic wait_words(input int unsigned n, input string tag);
        for (int k = 0; k < 60 && q.size() < qb + n; k++) @(negedge clk);
        check(tag, q.size() - qb, n);
    endtask

    task automatic wait_valid(input string tag);
        for (int k = 0; k < 30 && !bm.out_valid; k++) @(negedge clk);
        check(tag, {31'd0, bm.out_valid}, 32'd1);
    endtask

    task automatic check_word(input int unsigned idx, input logic [31:0] instr,
                              input logic [31:0] addr, input logic [2:0] cls);
        word_t w;
        if (idx < q.size()) begin
            w = q[idx];
            check($sformatf("instr[%0d]", idx), w.instr, instr);
            check($sformatf("addr[%0d]", idx), w.addr, addr);
            check($sformatf("cls[%0d]", idx), {29'd0, w.cls}, {29'd0, cls});
        end else begin
            check($sformatf("missing[%0d]", idx), idx, q.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned acc0;
        rst_n = 1'b0; clr = 1'b0;
        bm.in_valid = 1'b0; bm.out_ready = 1'b1;
        bm.in_type = 2'b00; bm.opcode = '0; bm.rs = '0; bm.rt = '0; bm.rd = '0;
        bm.shamt = '0; bm.funct = '0; bm.imm = '0; bm.target = '0;
        qb = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, bm.in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, bm.out_valid}, 32'd0);
        check("rst_out_instr", bm.out_instr, 32'd0);
        check("rst_out_addr", bm.out_addr, 32'd0);
        check("rst_cls", {29'd0, bm.out_r, bm.out_i, bm.out_j}, 32'd0);
        check("rst_err", {31'd0, bm.err}, 32'd0);
        check("rst_err_count", {24'd0, bm.err_count}, 32'd0);
        check("rst_small_addr", {28'd0, bs.out_addr}, 32'd12);
        rst_n = 1'b1;
        #1;
        check("release_in_ready", {31'd0, bm.in_ready}, 32'd1);
        @(negedge clk);

        // 1: single R word
        qb = q.size();
        send_r(5'd10, 5'd11, 5'd9, 5'd0, 6'h20);
        wait_words(1, "t1_count");
        check_word(qb, 32'h014B4820, 32'd0, 3'b100);

        // 2: I then J back to back
        qb = q.size();
        send_i(6'd8, 5'd24, 5'd18, 16'h0025);
        send_j(6'd2, 26'h0);
        wait_words(2, "t2_count");
        check_word(qb,     32'h23120025, 32'd4, 3'b010);
        check_word(qb + 1, 32'h08000000, 32'd8, 3'b001);

        // 3: illegal type, illegal I opcode, then a legal R
        qb = q.size();
        send_ill();
        send_i(6'd2, 5'd1, 5'd2, 16'h0001);
        send_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h21);
        wait_words(1, "t3_first");
        repeat (5) @(negedge clk);
        check("t3_count", q.size() - qb, 32'd1);
        check_word(qb, 32'h00221821, 32'd12, 3'b100);
        check("t3_err", {31'd0, bm.err}, 32'd1);
        check("t3_err_count", {24'd0, bm.err_count}, 32'd2);

        // 4: backpressure with 4 queued requests
        qb = q.size();
        bm.out_ready = 1'b0;
        acc0 = n_acc;
        fork
            begin
                send_r(5'd0, 5'd0, 5'd1, 5'd0, 6'h20);
                send_r(5'd0, 5'd0, 5'd2, 5'd0, 6'h20);
                send_r(5'd0, 5'd0, 5'd3, 5'd0, 6'h20);
                send_r(5'd0, 5'd0, 5'd4, 5'd0, 6'h20);
            end
            begin
                repeat (3) @(negedge clk);
                #1;
                check("bp_valid", {31'd0, bm.out_valid}, 32'd1);
                check("bp_instr_a", bm.out_instr, 32'h00000820);
                check("bp_addr_a", bm.out_addr, 32'd16);
                repeat (2) @(negedge clk);
                #1;
                check("bp_accepted", n_acc - acc0, 32'd2);
                check("bp_in_ready", {31'd0, bm.in_ready}, 32'd0);
                check("bp_instr_b", bm.out_instr, 32'h00000820);
                check("bp_addr_b", bm.out_addr, 32'd16);
                check("bp_out_r", {31'd0, bm.out_r}, 32'd1);
                bm.out_ready = 1'b1;
            end
        join
        wait_words(4, "t4_count");
        check_word(qb,     32'h00000820, 32'd16, 3'b100);
        check_word(qb + 1, 32'h00001020, 32'd20, 3'b100);
        check_word(qb + 2, 32'h00001820, 32'd24, 3'b100);
        check_word(qb + 3, 32'h00002020, 32'd28, 3'b100);

        // 5a: asynchronous reset with a word pending
        bm.out_ready = 1'b0;
        send_r(5'd0, 5'd0, 5'd5, 5'd0, 6'h20);
        wait_valid("t5_pending");
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, bm.out_valid}, 32'd0);
        check("arst_out_instr", bm.out_instr, 32'd0);
        check("arst_out_addr", bm.out_addr, 32'd0);
        check("arst_in_ready", {31'd0, bm.in_ready}, 32'd0);
        check("arst_err", {31'd0, bm.err}, 32'd0);
        check("arst_err_count", {24'd0, bm.err_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bm.out_ready = 1'b1;
        qb = q.size();
        send_r(5'd0, 5'd0, 5'd1, 5'd0, 6'h20);
        wait_words(1, "t5_after_rst");
        check_word(qb, 32'h00000820, 32'd0, 3'b100);
        check("t5_addr_next", bm.out_addr, 32'd4);

        // 5b: clr with a pending word and a coincident request
        send_ill();
        repeat (2) @(negedge clk);
        check("t5_err_set", {31'd0, bm.err}, 32'd1);
        bm.out_ready = 1'b0;
        send_r(5'd0, 5'd0, 5'd2, 5'd0, 6'h20);
        wait_valid("t5_pending2");
        clr = 1'b1;
        bm.in_type = 2'b00; bm.rd = 5'd7; bm.funct = 6'h20;
        bm.in_valid = 1'b1;
        acc0 = n_acc;
        #1;
        check("clr_in_ready", {31'd0, bm.in_ready}, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        bm.in_valid = 1'b0;
        check("clr_no_accept", n_acc - acc0, 32'd0);
        check("clr_out_valid", {31'd0, bm.out_valid}, 32'd0);
        check("clr_out_addr", bm.out_addr, 32'd0);
        check("clr_err", {31'd0, bm.err}, 32'd0);
        check("clr_err_count", {24'd0, bm.err_count}, 32'd0);
        bm.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("clr_dropped", q.size() - qb, 32'd1);

        // 6: address wrap and counter saturation on the narrow instance
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("wrap_base", {28'd0, bs.out_addr}, 32'd12);
        qb = q.size();
        send_r(5'd0, 5'd0, 5'd1, 5'd0, 6'h20);
        wait_words(1, "t6_first");
        check("wrap_after_first", {28'd0, bs.out_addr}, 32'd0);
        bm.out_ready = 1'b0;
        send_r(5'd0, 5'd0, 5'd2, 5'd0, 6'h20);
        wait_valid("t6_pending");
        check("wrap_second_valid", {31'd0, bs.out_valid}, 32'd1);
        check("wrap_second_addr", {28'd0, bs.out_addr}, 32'd0);
        bm.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) send_ill();
        repeat (3) @(negedge clk);
        check("sat_small_count", {30'd0, bs.err_count}, 32'd3);
        check("sat_small_err", {31'd0, bs.err}, 32'd1);
        check("sat_main_count", {24'd0, bm.err_count}, 32'd5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
